// File: rtl/sync_fifo_flex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_flex_pkg
// Description : Shared width helpers and read-mode encoding for sync_fifo_flex.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_flex_pkg;

    typedef enum logic {
        FIFO_MODE_STD  = 1'b0,
        FIFO_MODE_FWFT = 1'b1
    } fifo_mode_e;

    // Pointer width; a depth of one still needs a one-bit address.
    function automatic int FIFO_PTR_W(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count spans 0..depth inclusive.
    function automatic int FIFO_CNT_W(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_flex_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram
// Description : W x D simple dual-port array, synchronous write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram #(
    parameter int W  = 32,
    parameter int D  = 64,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] r_mem [D];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_flex
// Description : Single-clock FIFO with occupancy count, programmable
//               thresholds, sticky error flags and selectable FWFT read mode.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_flex
    import sync_fifo_flex_pkg::*;
#(
    parameter int W      = 32,
    parameter int D      = 64,
    parameter int AF_THR = D - 4,
    parameter int AE_THR = 4,
    parameter int FWFT   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wrt_en,
    input  logic [W-1:0]             data_in,
    input  logic                     rd_en,
    output logic [W-1:0]             data_out,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [FIFO_CNT_W(D)-1:0] count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int c_PW = FIFO_PTR_W(D);
    localparam int c_CW = FIFO_CNT_W(D);

    generate
        if (D < 2) begin : g_chk_depth
            $error("sync_fifo_flex: D must be >= 2");
        end
        if ((AF_THR < 1) || (AF_THR > D)) begin : g_chk_af
            $error("sync_fifo_flex: AF_THR must be in 1..D");
        end
        if ((AE_THR < 0) || (AE_THR >= D)) begin : g_chk_ae
            $error("sync_fifo_flex: AE_THR must be in 0..D-1");
        end
        if ((FWFT != 0) && (FWFT != 1)) begin : g_chk_mode
            $error("sync_fifo_flex: FWFT must be 0 or 1");
        end
    endgenerate

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_overflow;
    logic            r_underflow;
    logic            w_full;
    logic            w_empty;
    logic            w_wr_acc;
    logic            w_rd_acc;
    logic [W-1:0]    w_rdata;

    // Status is decoded from the registered count only.
    assign w_full       = (r_count == c_CW'(D));
    assign w_empty      = (r_count == '0);
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_CW'(AF_THR));
    assign almost_empty = (r_count <= c_CW'(AE_THR));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    assign w_wr_acc = wrt_en && !w_full;
    assign w_rd_acc = rd_en && !w_empty;

    fifo_ram #(
        .W  (W),
        .D  (D),
        .AW (c_PW)
    ) u_ram (
        .clk   (clk),
        .we    (w_wr_acc && !rst),
        .waddr (r_wr_ptr),
        .wdata (data_in),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    // Explicit wrap at D-1 keeps non-power-of-two depths correct.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= (r_wr_ptr == c_PW'(D - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= (r_rd_ptr == c_PW'(D - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A set condition takes priority over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wrt_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT == int'(FIFO_MODE_FWFT)) begin : g_fwft
            // Head word is presented directly; forced to zero while empty.
            assign data_out = w_empty ? '0 : w_rdata;
            assign rd_valid = !w_empty;
        end else begin : g_std
            logic [W-1:0] r_data_out;
            logic         r_rd_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data_out <= '0;
                    r_rd_valid <= 1'b0;
                end else if (w_rd_acc) begin
                    r_data_out <= w_rdata;
                    r_rd_valid <= 1'b1;
                end else begin
                    r_rd_valid <= 1'b0;
                end
            end

            assign data_out = r_data_out;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_flex
// Description : Self-checking bench; standard (D=5) and FWFT (D=4) instances
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_flex;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Standard-mode instance: W=8, D=5, AF_THR=3, AE_THR=1
    logic       s_rst = 1'b0, s_wr = 1'b0, s_rd = 1'b0, s_clr = 1'b0;
    logic [7:0] s_din = '0;
    logic [7:0] s_dout;
    logic       s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [2:0] s_cnt;

    // FWFT instance: W=8, D=4, AF_THR=3, AE_THR=1
    logic       f_rst = 1'b0, f_wr = 1'b0, f_rd = 1'b0, f_clr = 1'b0;
    logic [7:0] f_din = '0;
    logic [7:0] f_dout;
    logic       f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [2:0] f_cnt;

    sync_fifo_flex #(.W(8), .D(5), .AF_THR(3), .AE_THR(1), .FWFT(0)) u_std (
        .clk(clk), .rst(s_rst), .wrt_en(s_wr), .data_in(s_din), .rd_en(s_rd),
        .data_out(s_dout), .rd_valid(s_rv), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
        .overflow(s_ovf), .underflow(s_unf), .clr_err(s_clr)
    );

    sync_fifo_flex #(.W(8), .D(4), .AF_THR(3), .AE_THR(1), .FWFT(1)) u_fwft (
        .clk(clk), .rst(f_rst), .wrt_en(f_wr), .data_in(f_din), .rd_en(f_rd),
        .data_out(f_dout), .rd_valid(f_rv), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
        .overflow(f_ovf), .underflow(f_unf), .clr_err(f_clr)
    );

    // Reference model state
    logic [7:0] ms_q[$];
    logic       ms_ovf = 1'b0, ms_unf = 1'b0, ms_rv = 1'b0;
    logic [7:0] ms_dout = '0;
    logic [7:0] mf_q[$];
    logic       mf_ovf = 1'b0, mf_unf = 1'b0;

    function automatic logic [17:0] exp_s();
        int n = ms_q.size();
        return {ms_dout, ms_rv, n == 5, n == 0, n >= 3, n <= 1, 3'(n), ms_ovf, ms_unf};
    endfunction

    function automatic logic [17:0] exp_f();
        int n = mf_q.size();
        logic [7:0] head = (n > 0) ? mf_q[0] : 8'h00;
        return {head, n > 0, n == 4, n == 0, n >= 3, n <= 1, 3'(n), mf_ovf, mf_unf};
    endfunction

    // Advance one clock: model both FIFOs from the driven inputs, then release pulses.
    task automatic tick();
        if (s_rst) begin
            ms_q.delete(); ms_ovf = 0; ms_unf = 0; ms_dout = 0; ms_rv = 0;
        end else begin
            bit wa = s_wr && ms_q.size() < 5;
            bit ra = s_rd && ms_q.size() > 0;
            if (s_wr && ms_q.size() == 5) ms_ovf = 1; else if (s_clr) ms_ovf = 0;
            if (s_rd && ms_q.size() == 0) ms_unf = 1; else if (s_clr) ms_unf = 0;
            ms_rv = ra;
            if (ra) ms_dout = ms_q.pop_front();
            if (wa) ms_q.push_back(s_din);
        end
        if (f_rst) begin
            mf_q.delete(); mf_ovf = 0; mf_unf = 0;
        end else begin
            bit wa = f_wr && mf_q.size() < 4;
            bit ra = f_rd && mf_q.size() > 0;
            if (f_wr && mf_q.size() == 4) mf_ovf = 1; else if (f_clr) mf_ovf = 0;
            if (f_rd && mf_q.size() == 0) mf_unf = 1; else if (f_clr) mf_unf = 0;
            if (ra) void'(mf_q.pop_front());
            if (wa) mf_q.push_back(f_din);
        end
        @(posedge clk);
        #1;
        s_rst = 0; s_wr = 0; s_rd = 0; s_clr = 0;
        f_rst = 0; f_wr = 0; f_rd = 0; f_clr = 0;
    endtask

    task automatic test_reset();
        s_wr = 1; s_din = 8'h5A; f_wr = 1; f_din = 8'hA5;
        tick();
        s_rst = 1; f_rst = 1;
        tick();
        n_checks++;
        if ({s_cnt, s_empty, s_full, s_ae, s_af} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL reset_std_flags: got %b required %b",
                               {s_cnt, s_empty, s_full, s_ae, s_af}, 7'b0001010);
        end
        n_checks++;
        if ({s_dout, s_rv, s_ovf, s_unf} !== 11'd0) begin
            n_fail++; $display("FAIL reset_std_out: got %h required 0", {s_dout, s_rv, s_ovf, s_unf});
        end
        n_checks++;
        if ({f_cnt, f_empty, f_rv, f_dout, f_ovf, f_unf} !== {3'd0, 1'b1, 1'b0, 8'h00, 2'b00}) begin
            n_fail++; $display("FAIL reset_fwft: got %h required %h",
                               {f_cnt, f_empty, f_rv, f_dout, f_ovf, f_unf}, {3'd0, 1'b1, 10'd0});
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 5; i++) begin
            s_wr = 1; s_din = 8'(i);
            tick();
        end
        n_checks++;
        if ({s_full, s_cnt} !== {1'b1, 3'd5}) begin
            n_fail++; $display("FAIL fill_full: got full=%b count=%0d required full=1 count=5", s_full, s_cnt);
        end
        for (int i = 1; i <= 5; i++) begin
            s_rd = 1;
            tick();
            n_checks++;
            if ({s_rv, s_dout} !== {1'b1, 8'(i)}) begin
                n_fail++; $display("FAIL drain_data: got rv=%b data=%h required rv=1 data=%h", s_rv, s_dout, 8'(i));
            end
        end
        n_checks++;
        if ({s_empty, s_cnt} !== {1'b1, 3'd0}) begin
            n_fail++; $display("FAIL drain_empty: got empty=%b count=%0d required 1/0", s_empty, s_cnt);
        end
    endtask

    task automatic test_simul_rw();
        for (int i = 0; i < 3; i++) begin
            s_wr = 1; s_din = 8'h40 + 8'(i);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            s_wr = 1; s_rd = 1; s_din = 8'h80 + 8'(i);
            tick();
            n_checks++;
            if ({s_cnt, s_rv, s_dout} !== {3'd3, 1'b1, ms_dout}) begin
                n_fail++; $display("FAIL simul_rw: got count=%0d rv=%b data=%h required count=3 rv=1 data=%h",
                                   s_cnt, s_rv, s_dout, ms_dout);
            end
        end
    endtask

    task automatic test_overflow();
        while (ms_q.size() < 5) begin
            s_wr = 1; s_din = 8'h20 + 8'(ms_q.size());
            tick();
        end
        s_wr = 1; s_din = 8'hAA;
        tick();
        n_checks++;
        if ({s_ovf, s_cnt} !== {1'b1, 3'd5}) begin
            n_fail++; $display("FAIL overflow_set: got ovf=%b count=%0d required 1/5", s_ovf, s_cnt);
        end
        s_wr = 1; s_din = 8'hAA; s_clr = 1;
        tick();
        n_checks++;
        if (s_ovf !== 1'b1) begin
            n_fail++; $display("FAIL overflow_set_wins: got %b required 1", s_ovf);
        end
        s_clr = 1;
        tick();
        n_checks++;
        if (s_ovf !== 1'b0) begin
            n_fail++; $display("FAIL overflow_clear: got %b required 0", s_ovf);
        end
        for (int i = 0; i < 5; i++) begin
            s_rd = 1;
            tick();
            n_checks++;
            if (s_dout === 8'hAA || s_dout !== ms_dout) begin
                n_fail++; $display("FAIL overflow_drain: got %h required %h", s_dout, ms_dout);
            end
        end
    endtask

    task automatic test_underflow();
        s_wr = 1; s_rd = 1; s_din = 8'h3C;
        tick();
        n_checks++;
        if ({s_unf, s_cnt, s_rv} !== {1'b1, 3'd1, 1'b0}) begin
            n_fail++; $display("FAIL underflow_set: got unf=%b count=%0d rv=%b required 1/1/0", s_unf, s_cnt, s_rv);
        end
        s_rd = 1;
        tick();
        n_checks++;
        if ({s_rv, s_dout} !== {1'b1, 8'h3C}) begin
            n_fail++; $display("FAIL underflow_read: got rv=%b data=%h required 1/3c", s_rv, s_dout);
        end
        s_clr = 1;
        tick();
    endtask

    task automatic test_fwft();
        f_wr = 1; f_din = 8'h11;
        tick();
        n_checks++;
        if ({f_rv, f_dout} !== {1'b1, 8'h11}) begin
            n_fail++; $display("FAIL fwft_head: got rv=%b data=%h required 1/11", f_rv, f_dout);
        end
        f_rd = 1;
        tick();
        n_checks++;
        if ({f_empty, f_rv} !== 2'b10) begin
            n_fail++; $display("FAIL fwft_pop: got empty=%b rv=%b required 1/0", f_empty, f_rv);
        end
    endtask

    task automatic test_thresholds();
        logic [4:0] ae_exp = 5'b00011;
        logic [4:0] af_exp = 5'b11000;
        s_rst = 1;
        tick();
        for (int k = 0; k <= 4; k++) begin
            n_checks++;
            if ({s_ae, s_af} !== {ae_exp[k], af_exp[k]}) begin
                n_fail++; $display("FAIL thresholds_cnt%0d: got ae=%b af=%b required %b/%b",
                                   k, s_ae, s_af, ae_exp[k], af_exp[k]);
            end
            s_wr = 1; s_din = 8'hC0 + 8'(k);
            tick();
        end
        s_rd = 1; s_rst = 0;
        tick();
        s_rd = 1;
        tick();
        s_rst = 1; s_wr = 1; s_din = 8'hEE;
        tick();
        n_checks++;
        if ({s_cnt, s_empty, s_rv} !== {3'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL reset_midop: got count=%0d empty=%b rv=%b required 0/1/0", s_cnt, s_empty, s_rv);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            s_rst = ($urandom_range(0, 63) == 0); f_rst = ($urandom_range(0, 63) == 0);
            s_clr = ($urandom_range(0, 15) == 0); f_clr = ($urandom_range(0, 15) == 0);
            s_wr = ($urandom_range(0, 99) < 55);  f_wr = ($urandom_range(0, 99) < 50);
            s_rd = ($urandom_range(0, 99) < 50);  f_rd = ($urandom_range(0, 99) < 55);
            s_din = 8'($urandom); f_din = 8'($urandom);
            tick();
            n_checks++;
            if ({s_dout, s_rv, s_full, s_empty, s_af, s_ae, s_cnt, s_ovf, s_unf} !== exp_s()) begin
                n_fail++; $display("FAIL random_std cycle %0d: got %h required %h", i,
                                   {s_dout, s_rv, s_full, s_empty, s_af, s_ae, s_cnt, s_ovf, s_unf}, exp_s());
            end
            n_checks++;
            if ({f_dout, f_rv, f_full, f_empty, f_af, f_ae, f_cnt, f_ovf, f_unf} !== exp_f()) begin
                n_fail++; $display("FAIL random_fwft cycle %0d: got %h required %h", i,
                                   {f_dout, f_rv, f_full, f_empty, f_af, f_ae, f_cnt, f_ovf, f_unf}, exp_f());
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_fill_drain();
        test_simul_rw();
        test_overflow();
        test_underflow();
        test_fwft();
        test_thresholds();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Parametrised single-clock FIFO that succeeds the team's basic W×D synchronous FIFO. It corrects the simultaneous read/write occupancy update and adds a live occupancy count, programmable almost-full/almost-empty thresholds, and a selectable first-word-fall-through (FWFT) read mode. It also adds sticky overflow/underflow error flags. It sits between producer and consumer stages in the same clock domain.

## Interface
- `W`, 32: data width in bits, ≥1.
- `D`, 64: depth in entries, ≥2, any integer (not restricted to a power of two).
- `AF_THR`, D-4: `almost_full` asserts when count ≥ `AF_THR`; legal range 1..D.
- `AE_THR`, 4: `almost_empty` asserts when count ≤ `AE_THR`; legal range 0..D-1.
- `FWFT`, 0: 0 = standard registered read; 1 = first-word-fall-through.
---
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high. Clears pointers, count, `data_out`, `rd_valid` and error flags. Memory contents are not cleared.
- `wrt_en` in 1: write request.
- `data_in` in W: write data.
- `rd_en` in 1: read request. In FWFT mode it acts as the pop/acknowledge of the head word.
- `data_out` out W: read data.
- `rd_valid` out 1: `data_out` holds valid data.
- `full` out 1: count == D.
- `empty` out 1: count == 0.
- `almost_full` out 1: count ≥ AF_THR.
- `almost_empty` out 1: count ≤ AE_THR.
- `count` out $clog2(D+1): current occupancy, 0..D.
- `overflow` out 1: sticky; set by a write attempt while full.
- `underflow` out 1: sticky; set by a read attempt while empty.
- `clr_err` in 1: synchronous clear of `overflow` and `underflow`.

## Operation
- Write accept: `wr_acc` = `wrt_en` && !`full`. Read accept: `rd_acc` = `rd_en` && !`empty`. Both are evaluated on the state before the clock edge.
- Write gating uses `full` only. When full and `wrt_en` && `rd_en` are both asserted, only the read is accepted and `overflow` sets.
- When empty and both are asserted, only the write is accepted and `underflow` sets.
- Count update:
  - +1 on `wr_acc` && !`rd_acc`.
  - −1 on `rd_acc` && !`wr_acc`.
  - Unchanged when both are accepted.
  - Count never leaves the range 0..D.
- Pointers are $clog2(D) bits wide and wrap from D-1 to 0 explicitly. This keeps non-power-of-two depths correct.
- `full`, `empty`, `almost_full` and `almost_empty` are decoded combinationally from the registered `count`.
- Error flags:
  - `overflow` sets on `wrt_en` && `full`.
  - `underflow` sets on `rd_en` && `empty`.
  - Each flag holds until `rst` or `clr_err`.
  - If a set condition and `clr_err` occur in the same cycle, set wins.
- Standard mode (FWFT=0):
  - On `rd_acc`, `data_out` <= mem[r_ptr] and `rd_valid` <= 1. Otherwise `rd_valid` <= 0 and `data_out` holds its value.
- FWFT mode (FWFT=1):
  - `data_out` = mem[r_ptr], combinational.
  - `rd_valid` = !`empty`.
  - `rd_en` pops the head word.
  - A word written into an empty FIFO appears on `data_out` the cycle after the write.
- Reset mid-operation: all state returns to empty on the next edge. An in-flight accept in that same cycle is discarded.

## Timing
- Reset values:
  - `count` = 0, `empty` = 1, `full` = 0.
  - `almost_empty` = 1 (AE_THR ≥ 0).
  - `almost_full` = 0.
  - `data_out` = 0, `rd_valid` = 0.
  - `overflow` = 0, `underflow` = 0.
- Write-to-flag latency: 1 cycle. Flags reflect the count after the edge.
- Read latency: standard mode 1 cycle from `rd_acc` to `rd_valid`; FWFT mode 0 cycles (data is present while `rd_valid` = 1).
- Write-to-read minimum latency, empty FIFO: write at edge N; readable (FWFT head visible, or standard `rd_en` accepted) from cycle N+1.
- Sustained throughput is 1 write + 1 read per cycle at any occupancy 1..D-1.

## Structure
- Shared package holds:
  - `FIFO_PTR_W(D)` and `FIFO_CNT_W(D)` width helper constants.
  - An enum/localparam for mode: `FIFO_MODE_STD` = 0, `FIFO_MODE_FWFT` = 1.
- Sub-module `fifo_ram`: a W×D simple dual-port array with a synchronous write and an asynchronous read address. The top contains the pointer, count and flag logic plus the mode-dependent output stage.
- Parameter checks run at elaboration: D ≥ 2, 1 ≤ AF_THR ≤ D, 0 ≤ AE_THR < D.

## Test plan
- Fill and drain, W=8, D=5 (non-power-of-two), FWFT=0:
  - Write 0x01..0x05 → `full`=1, `count`=5.
  - Read 5 → `data_out` 0x01..0x05 in order, each with `rd_valid` one cycle after its read, then `empty`=1.
- Simultaneous read and write at count=3 for 10 cycles → `count` stays 3 and ordering is preserved across the pointer wrap.
- Overflow: with the FIFO full, pulse `wrt_en` with data 0xAA → `overflow`=1, `count`=5, and 0xAA is never read out. Then `clr_err` → `overflow`=0.
- Underflow/empty case: with the FIFO empty, assert `wrt_en`=`rd_en`=1 with data 0x3C → `underflow`=1, `count`=1. The next read returns 0x3C.
- FWFT=1, D=4: write 0x11 at edge N → `rd_valid`=1 and `data_out`=0x11 in cycle N+1 with no `rd_en`. Pop → `empty`=1.
- Thresholds and reset, AF_THR=3, AE_THR=1:
  - Counts 0..4 → `almost_empty` is 1,1,0,0,0 and `almost_full` is 0,0,0,1,1.
  - Assert `rst` at count=3 → next cycle `count`=0, `empty`=1, `rd_valid`=0.
